bufer_ex_mem: RTL and testbench
===============================

Name: bufer_ex_mem

Overview:
- Clocked EX/MEM pipeline register between the execute stage (fed by the ID/EX buffer) and the data-memory stage.
- Carries the ALU result, store data, destination register, branch target, zero flag and MEM/WB control bits.
- Uses a valid/ready handshake with a 2-entry skid buffer, so a stalling data memory backpressures EX without a combinational ready path.
- Flush input kills in-flight entries on a taken branch.

Parameters:
- DATA_W, 32, width of ALU result, store data and branch target
- REG_W, 5, width of destination register index
- CTRL_W, 5, width of control bundle: bit0 RegWrite, bit1 MemToReg, bit2 MemRead, bit3 MemWrite, bit4 Branch

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  EX presents a valid instruction
- in_ready  out  1  block can accept; registered
- in_alu  in  DATA_W  ALU result
- in_wdata  in  DATA_W  store data (second read operand)
- in_target  in  DATA_W  branch target (PC+4 + offset<<2)
- in_zero  in  1  ALU zero flag
- in_rd  in  REG_W  destination register
- in_ctrl  in  CTRL_W  control bundle
- out_valid  out  1  MEM stage entry valid
- out_ready  in  1  MEM stage accepts this cycle
- out_alu, out_wdata, out_target  out  DATA_W  head-entry payload
- out_zero  out  1  head zero flag
- out_rd  out  REG_W  head destination
- out_ctrl  out  CTRL_W  head control; forced 0 when out_valid=0
- pc_src  out  1  out_valid & out_ctrl[4] & out_zero (combinational from registers)
- occupancy  out  2  entries held: 0, 1 or 2

Behaviour:
- Storage: main register (head, drives out_*) and skid register, each with its own valid bit. State is encoded by occupancy: EMPTY=0, ONE=1, FULL=2.
- Handshake:
  - accept = in_valid & in_ready
  - pop = out_valid & out_ready
  - in_ready = ~skid_valid, taken directly from a flop.
- Transitions:
  - EMPTY + accept -> ONE; entry loads into main, visible on out_* the next cycle (1-cycle latency).
  - ONE + accept & pop -> ONE; main reloads with the new entry.
  - ONE + accept & ~pop -> FULL; the new entry goes to skid and in_ready drops the next cycle.
  - ONE + pop & ~accept -> EMPTY.
  - FULL + pop -> ONE; skid moves to main. No accept is possible, since in_ready=0.
  - FULL + ~pop -> FULL; all outputs hold.
- Stability: while out_valid=1 and out_ready=0, every out_* bit must stay constant.
- Ordering: strict FIFO. No entry is dropped or duplicated except by flush.
- Flush:
  - Next edge clears both valid bits; occupancy becomes 0 and in_ready becomes 1.
  - Flush wins over a simultaneous accept (the input is dropped) and over a simultaneous pop (the pop still counts as consumed by MEM).
  - Data registers may keep stale payload, but out_ctrl reads 0.
- Reset (asynchronous, active-high, may assert mid-operation):
  - All valid bits, payload registers and outputs go to 0 immediately; occupancy=0; pc_src=0.
  - in_ready=1 while rst is high and after release.
  - The first accept is possible on the first edge after deassertion.
- Bubbles: out_valid=0 implies out_ctrl=0 and pc_src=0, so MEM/WB never sees a spurious write.
- Widths: pure pass-through, no arithmetic. pc_src is only a 3-input AND.

Decomposition:
- Shared package holds the CTRL_W bit-index constants (CTRL_REGWRITE=0, CTRL_MEMTOREG=1, CTRL_MEMREAD=2, CTRL_MEMWRITE=3, CTRL_BRANCH=4) and the default widths. The ID/EX, EX/MEM and MEM/WB buffers all use it.
- One natural sub-module, skid_reg: a generic 2-entry valid/ready skid buffer over a flat payload of width 2*DATA_W+DATA_W+1+REG_W+CTRL_W. bufer_ex_mem instantiates it and adds the ctrl gating and pc_src.

Test Plan:
- Reset mid-stream: occupancy=2, assert rst asynchronously between edges -> out_valid=0, out_ctrl=0, in_ready=1 without waiting for a clock edge.
- Streaming: out_ready=1, 4 back-to-back entries with in_alu=0x10,0x20,0x30,0x40 -> appear on out_alu in order, each 1 cycle later; occupancy stays 1; in_ready stays 1.
- Backpressure: out_ready=0, push 0xA then 0xB -> occupancy=2, in_ready=0 from the next cycle, out_alu holds 0xA. Raise out_ready -> 0xA then 0xB pop, and in_ready=1 one cycle after the first pop.
- Branch: in_ctrl=5'b10000, in_zero=1, in_target=0x0000_0040 -> pc_src=1 and out_target=0x40 the next cycle. Same with in_zero=0 -> pc_src=0.
- Flush collision: occupancy=1, same cycle flush=1, in_valid=1, out_ready=1 -> next cycle out_valid=0, occupancy=0, out_ctrl=0; the new entry never appears.
- Store gating: entry in_ctrl=5'b01000 held under out_ready=0 for 3 cycles -> out_ctrl=5'b01000 and out_wdata stable for all 3 cycles; after pop with no new input, out_ctrl=0.

Source files
------------

// File: rtl/bufer_ex_mem_pkg.sv
// rtl/bufer_ex_mem_pkg.sv - shared widths, control-bit indices and occupancy encoding for pipeline buffers
package bufer_ex_mem_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;
  localparam int DEF_CTRL_W = 5;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_BRANCH   = 4;

  // Encoding doubles as the occupancy count seen on the port.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_t;

endpackage

// File: rtl/bufer_ex_mem_skid.sv
// rtl/bufer_ex_mem_skid.sv - generic 2-entry valid/ready skid buffer with registered in_ready
module skid_reg
  import bufer_ex_mem_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  occ_state_t state, state_next;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             ready_q;
  logic             accept;
  logic             pop;
  logic             load_main;
  logic             main_from_skid;
  logic             load_skid;

  assign in_ready  = ready_q;
  assign out_valid = (state != OCC_EMPTY);
  assign out_data  = main_q;
  assign occupancy = state;
  assign accept    = in_valid & ready_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_next     = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      OCC_EMPTY: begin
        if (accept) begin
          state_next = OCC_ONE;
          load_main  = 1'b1;
        end
      end
      OCC_ONE: begin
        case ({accept, pop})
          2'b11:   load_main = 1'b1;
          2'b10: begin
            state_next = OCC_FULL;
            load_skid  = 1'b1;
          end
          2'b01:   state_next = OCC_EMPTY;
          default: state_next = OCC_ONE;
        endcase
      end
      OCC_FULL: begin
        if (pop) begin
          state_next     = OCC_ONE;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_next = OCC_EMPTY;
    endcase
    // Payload may still load on a flush; only the valid state matters.
    if (flush) begin
      state_next = OCC_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= OCC_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state   <= state_next;
      ready_q <= (state_next != OCC_FULL);
      if (load_main) begin
        main_q <= main_from_skid ? skid_q : in_data;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/bufer_ex_mem.sv
// rtl/bufer_ex_mem.sv - EX/MEM pipeline register with skid-buffer backpressure, flush and branch decision
module bufer_ex_mem
  import bufer_ex_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [DATA_W-1:0] in_target,
  input  logic              in_zero,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_wdata,
  output logic [DATA_W-1:0] out_target,
  output logic              out_zero,
  output logic [REG_W-1:0]  out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              pc_src,
  output logic [1:0]        occupancy
);

  localparam int PAYLOAD_W = 3 * DATA_W + 1 + REG_W + CTRL_W;

  logic [PAYLOAD_W-1:0] in_payload;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [CTRL_W-1:0]    head_ctrl;

  assign in_payload = {in_alu, in_wdata, in_target, in_zero, in_rd, in_ctrl};

  skid_reg #(
    .WIDTH(PAYLOAD_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload),
    .occupancy (occupancy)
  );

  assign {out_alu, out_wdata, out_target, out_zero, out_rd, head_ctrl} = out_payload;

  // Bubbles carry no control so MEM/WB never sees a stale write or branch.
  assign out_ctrl = out_valid ? head_ctrl : '0;
  assign pc_src   = out_valid & out_ctrl[CTRL_BRANCH] & out_zero;

endmodule

// File: tb/tb_bufer_ex_mem.sv
// tb/tb_bufer_ex_mem.sv - scoreboard bench for bufer_ex_mem
module tb_bufer_ex_mem;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [31:0] target;
    logic        zero;
    logic [4:0]  rd;
    logic [4:0]  ctrl;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu;
  logic [31:0] in_wdata;
  logic [31:0] in_target;
  logic        in_zero;
  logic [4:0]  in_rd;
  logic [4:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_alu;
  logic [31:0] out_wdata;
  logic [31:0] out_target;
  logic        out_zero;
  logic [4:0]  out_rd;
  logic [4:0]  out_ctrl;
  logic        pc_src;
  logic [1:0]  occupancy;

  ent_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  bufer_ex_mem dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_alu     (in_alu),
    .in_wdata   (in_wdata),
    .in_target  (in_target),
    .in_zero    (in_zero),
    .in_rd      (in_rd),
    .in_ctrl    (in_ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_alu    (out_alu),
    .out_wdata  (out_wdata),
    .out_target (out_target),
    .out_zero   (out_zero),
    .out_rd     (out_rd),
    .out_ctrl   (out_ctrl),
    .pc_src     (pc_src),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] wdata, input logic [31:0] target,
                       input logic zero, input logic [4:0] rd, input logic [4:0] ctrl);
    ent_t e;
    in_valid  = 1'b1;
    in_alu    = alu;
    in_wdata  = wdata;
    in_target = target;
    in_zero   = zero;
    in_rd     = rd;
    in_ctrl   = ctrl;
    e = '{alu: alu, wdata: wdata, target: target, zero: zero, rd: rd, ctrl: ctrl};
    if (in_ready && !flush && !rst) exp_q.push_back(e);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Monitor: every handshake pop on MEM side is matched against the scoreboard head.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pop: got alu 0x%0h expected no entry at %0t", out_alu, $time);
        end else begin
          e = exp_q.pop_front();
          chk("pop_alu",    out_alu,    e.alu);
          chk("pop_wdata",  out_wdata,  e.wdata);
          chk("pop_target", out_target, e.target);
          chk("pop_zero",   32'(out_zero), 32'(e.zero));
          chk("pop_rd",     32'(out_rd),   32'(e.rd));
          chk("pop_ctrl",   32'(out_ctrl), 32'(e.ctrl));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; in_alu = '0; in_wdata = '0; in_target = '0;
    in_zero = 1'b0; in_rd = '0; in_ctrl = '0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_ctrl",  32'(out_ctrl),  32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_pc_src",    32'(pc_src),    32'd0);
    step(); step();
    #2 rst = 1'b0;
    step();

    // Streaming: one entry per cycle, occupancy pinned at 1.
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(32'(i * 16), 32'(100 + i), 32'(200 + i), 1'b0, 5'(i), 5'b00001);
      step();
      chk("stream_occ",   32'(occupancy), 32'd1);
      chk("stream_ready", 32'(in_ready),  32'd1);
      chk("stream_alu",   out_alu,        32'(i * 16));
    end
    idle();
    step();
    chk("stream_drain_occ", 32'(occupancy), 32'd0);

    // Backpressure into the skid slot.
    out_ready = 1'b0;
    drive(32'hA, 32'h1A, 32'h2A, 1'b0, 5'd10, 5'b00011);
    step();
    drive(32'hB, 32'h1B, 32'h2B, 1'b0, 5'd11, 5'b00101);
    step();
    idle();
    chk("bp_occ_full",  32'(occupancy), 32'd2);
    chk("bp_ready_low", 32'(in_ready),  32'd0);
    chk("bp_head",      out_alu,        32'hA);
    step();
    chk("bp_hold_head", out_alu,        32'hA);
    chk("bp_hold_occ",  32'(occupancy), 32'd2);
    out_ready = 1'b1;
    step();
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    chk("bp_second",     out_alu,       32'hB);
    step();
    chk("bp_empty", 32'(occupancy), 32'd0);

    // Branch decision.
    drive(32'h0, 32'h0, 32'h0000_0040, 1'b1, 5'd0, 5'b10000);
    step();
    idle();
    chk("br_taken_pc_src", 32'(pc_src), 32'd1);
    chk("br_target",       out_target,  32'h40);
    step();
    drive(32'h1, 32'h0, 32'h0000_0040, 1'b0, 5'd0, 5'b10000);
    step();
    idle();
    chk("br_not_taken_pc_src", 32'(pc_src), 32'd0);
    step();
    chk("br_bubble_pc_src", 32'(pc_src), 32'd0);

    // Store held under backpressure, then gated once popped.
    out_ready = 1'b0;
    drive(32'h100, 32'h1234_5678, 32'h0, 1'b0, 5'd3, 5'b01000);
    step();
    idle();
    for (int c = 0; c < 3; c++) begin
      chk("st_ctrl_hold",  32'(out_ctrl), 32'b01000);
      chk("st_wdata_hold", out_wdata,     32'h1234_5678);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("st_ctrl_gated", 32'(out_ctrl),  32'd0);
    chk("st_valid_low",  32'(out_valid), 32'd0);

    // Flush colliding with accept and pop.
    out_ready = 1'b0;
    drive(32'h55, 32'h0, 32'h0, 1'b0, 5'd5, 5'b00001);
    step();
    chk("fl_occ_one", 32'(occupancy), 32'd1);
    flush = 1'b1;
    out_ready = 1'b1;
    drive(32'hDEAD, 32'h0, 32'h0, 1'b0, 5'd6, 5'b00001);
    step();
    flush = 1'b0;
    idle();
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_occ",       32'(occupancy), 32'd0);
    chk("fl_out_ctrl",  32'(out_ctrl),  32'd0);
    chk("fl_in_ready",  32'(in_ready),  32'd1);
    step();
    chk("fl_no_ghost", 32'(out_valid), 32'd0);

    // Asynchronous reset while full.
    out_ready = 1'b0;
    drive(32'h77, 32'h0, 32'h0, 1'b0, 5'd7, 5'b00001);
    step();
    drive(32'h88, 32'h0, 32'h0, 1'b0, 5'd8, 5'b00001);
    step();
    idle();
    chk("ar_occ_full", 32'(occupancy), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_out_ctrl",  32'(out_ctrl),  32'd0);
    chk("ar_in_ready",  32'(in_ready),  32'd1);
    chk("ar_occ",       32'(occupancy), 32'd0);
    chk("ar_out_alu",   out_alu,        32'd0);
    exp_q.delete();
    step();
    #2 rst = 1'b0;
    out_ready = 1'b1;
    drive(32'h99, 32'h9, 32'h90, 1'b0, 5'd9, 5'b00101);
    step();
    idle();
    chk("ar_first_accept", 32'(out_valid), 32'd1);
    chk("ar_first_alu",    out_alu,        32'h99);

    for (int w = 0; w < 20 && exp_q.size() != 0; w++) step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
